// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a 16x8 synchronous-enable ROM.
// One requester owns the ROM per transfer: IDLE -> ACCESS (WAIT_CYCLES) -> DONE (gnt pulse).
module rom_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] addr0,
  input  logic       req1,
  input  logic [3:0] addr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [3:0] rom_addr,
  output logic       rom_en,
  output logic       rom_ce,
  input  logic [7:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_ptr;
  logic       w_ptr_next;
  logic       r_owner;
  logic       w_owner_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [3:0] r_rom_addr;
  logic [3:0] w_rom_addr_next;
  logic [7:0] r_rdata;
  logic [7:0] w_rdata_next;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_busy;
  logic       r_rom_en;
  logic       r_rom_ce;
  logic       w_pick;

  // A lone requester always wins; on contention the one that was not last served wins.
  function automatic logic pick_owner(input logic a_req0, input logic a_req1,
                                      input logic a_last);
    logic v_win;
    if (a_req0 && a_req1) begin
      v_win = ~a_last;
    end else if (a_req1) begin
      v_win = 1'b1;
    end else begin
      v_win = 1'b0;
    end
    return v_win;
  endfunction

  assign w_pick = pick_owner(req0, req1, r_ptr);

  // Next-state, datapath and pointer update for the transfer sequence
  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_owner_next    = r_owner;
    w_cnt_next      = r_cnt;
    w_rom_addr_next = r_rom_addr;
    w_rdata_next    = r_rdata;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_owner_next    = w_pick;
          w_rom_addr_next = w_pick ? addr1 : addr0;
          w_cnt_next      = LOAD_VAL;
          w_state_next    = ACCESS;
        end else begin
          w_state_next = IDLE;
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_rdata_next = rom_data;
          w_state_next = DONE;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
          w_state_next = ACCESS;
        end
      end
      DONE: begin
        w_ptr_next   = r_owner;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b1;
      r_owner    <= 1'b0;
      r_cnt      <= 4'd0;
      r_rom_addr <= 4'h0;
      r_rdata    <= 8'h00;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_busy     <= 1'b0;
      r_rom_en   <= 1'b0;
      r_rom_ce   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_owner    <= w_owner_next;
      r_cnt      <= w_cnt_next;
      r_rom_addr <= w_rom_addr_next;
      r_rdata    <= w_rdata_next;
      r_gnt0     <= (w_state_next == DONE) && (w_owner_next == 1'b0);
      r_gnt1     <= (w_state_next == DONE) && (w_owner_next == 1'b1);
      r_busy     <= (w_state_next != IDLE);
      r_rom_en   <= (w_state_next == ACCESS);
      r_rom_ce   <= (w_state_next == ACCESS);
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign rom_addr = r_rom_addr;
  assign rom_en   = r_rom_en;
  assign rom_ce   = r_rom_ce;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: two instances (WAIT_CYCLES 1 and 3), each on its own ROM model,
// with a grant scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_rom_arbiter;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       a_req0, a_req1, b_req0, b_req1;
  logic [3:0] a_addr0, a_addr1, b_addr0, b_addr1;
  logic       a_gnt0, a_gnt1, b_gnt0, b_gnt1;
  logic [7:0] a_rdata, b_rdata;
  logic       a_busy, b_busy;
  logic [3:0] a_rom_addr, b_rom_addr;
  logic       a_rom_en, a_rom_ce, b_rom_en, b_rom_ce;
  wire  [7:0] a_rom_data, b_rom_data;

  int   n_cmp;
  int   n_fail;
  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [7:0] rom_word(input logic [3:0] a);
    logic [7:0] v;
    case (a)
      4'h0: v = 8'h0A;  4'h1: v = 8'h37;  4'h2: v = 8'hF4;  4'h3: v = 8'h00;
      4'h4: v = 8'h09;  4'h5: v = 8'hFF;  4'h6: v = 8'h11;  4'h7: v = 8'h01;
      4'h8: v = 8'h10;  4'h9: v = 8'h15;  4'hA: v = 8'h1D;  4'hB: v = 8'h25;
      4'hC: v = 8'h60;  4'hD: v = 8'h90;  4'hE: v = 8'h70;  4'hF: v = 8'h91;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic exp_t mk(input logic owner, input logic [7:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    return e;
  endfunction

  assign a_rom_data = (a_rom_en && a_rom_ce) ? rom_word(a_rom_addr) : 8'hzz;
  assign b_rom_data = (b_rom_en && b_rom_ce) ? rom_word(b_rom_addr) : 8'hzz;

  rom_arbiter #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(a_req0), .addr0(a_addr0), .req1(a_req1), .addr1(a_addr1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rdata(a_rdata), .busy(a_busy),
    .rom_addr(a_rom_addr), .rom_en(a_rom_en), .rom_ce(a_rom_ce), .rom_data(a_rom_data)
  );

  rom_arbiter #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .addr0(b_addr0), .req1(b_req1), .addr1(b_addr1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rdata(b_rdata), .busy(b_busy),
    .rom_addr(b_rom_addr), .rom_en(b_rom_en), .rom_ce(b_rom_ce), .rom_data(b_rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Grant monitor: every grant must match the head of its scoreboard and never overlap
  always @(negedge clk) begin : mon
    exp_t e;
    if (a_gnt0 || a_gnt1) begin
      chk("a_gnt_overlap", {31'd0, a_gnt0 & a_gnt1}, 32'd0);
      chk("a_sb_empty_at_gnt", {31'd0, qa.size() == 0}, 32'd0);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_gnt_owner", {31'd0, a_gnt1}, {31'd0, e.owner});
        chk("a_gnt_rdata", {24'd0, a_rdata}, {24'd0, e.data});
      end
    end
    if (b_gnt0 || b_gnt1) begin
      chk("b_gnt_overlap", {31'd0, b_gnt0 & b_gnt1}, 32'd0);
      chk("b_sb_empty_at_gnt", {31'd0, qb.size() == 0}, 32'd0);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_gnt_owner", {31'd0, b_gnt1}, {31'd0, e.owner});
        chk("b_gnt_rdata", {24'd0, b_rdata}, {24'd0, e.data});
      end
    end
  end

  initial begin : stim
    int got;
    int last;
    int en_cnt;
    n_cmp  = 0;
    n_fail = 0;
    a_req0 = 1'b0; a_req1 = 1'b0; a_addr0 = 4'h0; a_addr1 = 4'h0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_addr0 = 4'h0; b_addr1 = 4'h0;
    rst    = 1'b1;
    tick();
    tick();
    chk("rst_busy",     {31'd0, a_busy},     32'd0);
    chk("rst_rom_en",   {31'd0, a_rom_en},   32'd0);
    chk("rst_rom_ce",   {31'd0, a_rom_ce},   32'd0);
    chk("rst_gnt0",     {31'd0, a_gnt0},     32'd0);
    chk("rst_gnt1",     {31'd0, a_gnt1},     32'd0);
    chk("rst_rdata",    {24'd0, a_rdata},    32'd0);
    chk("rst_rom_addr", {28'd0, a_rom_addr}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_noreq_busy", {31'd0, a_busy}, 32'd0);

    // Single request, WAIT_CYCLES=1
    a_addr0 = 4'h2;
    a_req0  = 1'b1;
    qa.push_back(mk(1'b0, 8'hF4));
    tick();
    chk("s1_c1_en",    {31'd0, a_rom_en},   32'd1);
    chk("s1_c1_ce",    {31'd0, a_rom_ce},   32'd1);
    chk("s1_c1_busy",  {31'd0, a_busy},     32'd1);
    chk("s1_c1_addr",  {28'd0, a_rom_addr}, 32'd2);
    chk("s1_c1_gnt0",  {31'd0, a_gnt0},     32'd0);
    tick();
    chk("s1_c2_gnt0",  {31'd0, a_gnt0},     32'd1);
    chk("s1_c2_rdata", {24'd0, a_rdata},    32'hF4);
    chk("s1_c2_en",    {31'd0, a_rom_en},   32'd0);
    a_req0 = 1'b0;
    tick();
    chk("s1_c3_busy",  {31'd0, a_busy},     32'd0);
    chk("s1_c3_gnt0",  {31'd0, a_gnt0},     32'd0);
    chk("s1_c3_rdata", {24'd0, a_rdata},    32'hF4);
    chk("s1_c3_addr",  {28'd0, a_rom_addr}, 32'd2);

    // Simultaneous requests straight after reset: requester 0 first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_addr0 = 4'h5; a_addr1 = 4'hF;
    a_req0  = 1'b1; a_req1  = 1'b1;
    qa.push_back(mk(1'b0, 8'hFF));
    qa.push_back(mk(1'b1, 8'h91));
    got = 0;
    for (int c = 1; c <= 20 && got < 2; c++) begin
      tick();
      if (a_gnt0) begin a_req0 = 1'b0; got++; end
      if (a_gnt1) begin a_req1 = 1'b0; got++; end
    end
    chk("s2_grants", got, 32'd2);
    tick();
    chk("s2_idle_busy", {31'd0, a_busy}, 32'd0);

    // Both held continuously: alternating grants every 3 cycles
    a_addr0 = 4'h0; a_addr1 = 4'h1;
    a_req0  = 1'b1; a_req1  = 1'b1;
    qa.push_back(mk(1'b0, 8'h0A));
    qa.push_back(mk(1'b1, 8'h37));
    qa.push_back(mk(1'b0, 8'h0A));
    got  = 0;
    last = 0;
    for (int c = 1; c <= 30 && got < 3; c++) begin
      tick();
      if (a_gnt0 || a_gnt1) begin
        if (got == 0) chk("s3_first_cycle", c, 32'd2);
        else          chk("s3_spacing", c - last, 32'd3);
        last = c;
        got++;
        if (got == 3) begin a_req0 = 1'b0; a_req1 = 1'b0; end
      end
    end
    chk("s3_grants", got, 32'd3);
    tick();
    tick();
    chk("s3_idle_busy", {31'd0, a_busy}, 32'd0);

    // WAIT_CYCLES=3 instance: three enable cycles, grant in cycle 4
    b_addr1 = 4'hC;
    b_req1  = 1'b1;
    qb.push_back(mk(1'b1, 8'h60));
    en_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("s4_rom_en", {31'd0, b_rom_en}, {31'd0, (c >= 1 && c <= 3)});
      chk("s4_gnt1",   {31'd0, b_gnt1},   {31'd0, (c == 4)});
      if (b_rom_en) en_cnt++;
      if (b_gnt1) b_req1 = 1'b0;
    end
    chk("s4_en_cycles", en_cnt, 32'd3);

    // Reset in the middle of ACCESS aborts the transfer without a clock edge
    a_addr0 = 4'hD;
    a_req0  = 1'b1;
    tick();
    chk("s5_access_en",   {31'd0, a_rom_en},   32'd1);
    chk("s5_access_addr", {28'd0, a_rom_addr}, 32'hD);
    #1 rst = 1'b1;
    #1;
    chk("s5_async_busy",  {31'd0, a_busy},     32'd0);
    chk("s5_async_en",    {31'd0, a_rom_en},   32'd0);
    chk("s5_async_ce",    {31'd0, a_rom_ce},   32'd0);
    chk("s5_async_rdata", {24'd0, a_rdata},    32'd0);
    chk("s5_async_addr",  {28'd0, a_rom_addr}, 32'd0);
    chk("s5_async_gnt0",  {31'd0, a_gnt0},     32'd0);
    tick();
    chk("s5_held_gnt0",   {31'd0, a_gnt0},     32'd0);
    chk("s5_held_busy",   {31'd0, a_busy},     32'd0);
    rst = 1'b0;
    qa.push_back(mk(1'b0, 8'h90));
    got = 0;
    for (int c = 1; c <= 10 && got < 1; c++) begin
      tick();
      if (a_gnt0) begin
        chk("s5_gnt_cycle", c, 32'd2);
        a_req0 = 1'b0;
        got++;
      end
    end
    chk("s5_grants", got, 32'd1);
    tick();
    chk("sb_a_drained", qa.size(), 32'd0);
    chk("sb_b_drained", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, ROM access cycles (range 1..15) with en/ce asserted before data capture.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req0, input, 1, requester 0 read request; held high until gnt0.
REQ-005 SHALL have port addr0, input, 4, requester 0 ROM address; stable while req0 high.
REQ-006 SHALL have port req1, input, 1, requester 1 read request; held high until gnt1.
REQ-007 SHALL have port addr1, input, 4, requester 1 ROM address; stable while req1 high.
REQ-008 SHALL have port gnt0, output, 1, one-cycle pulse: rdata valid for requester 0.
REQ-009 SHALL have port gnt1, output, 1, one-cycle pulse: rdata valid for requester 1.
REQ-010 SHALL have port rdata, output, 8, registered read data.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port rom_addr, output, 4, registered address to the 16x8 ROM.
REQ-013 SHALL have port rom_en, output, 1, ROM enable.
REQ-014 SHALL have port rom_ce, output, 1, ROM chip enable.
REQ-015 SHALL have port rom_data, input, 8, ROM data; high-Z whenever en or ce is low.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-017 IDLE: with no request, the FSM SHALL stay in IDLE; with any request, it SHALL select the owner, latch the owner's address into rom_addr, load the wait counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-018 Arbitration SHALL be round-robin using a last-owner pointer (reset value 1). If both requesters are active, the requester not equal to the pointer SHALL win. If only one requester is active, it SHALL win regardless of the pointer.
REQ-019 ACCESS: rom_en and rom_ce SHALL be 1 and the counter SHALL decrement each cycle. When the counter is 0, rdata SHALL capture rom_data on that edge and the FSM SHALL enter DONE.
REQ-020 DONE: the owner's gnt SHALL be 1 for exactly one cycle, the pointer SHALL be updated to the owner, and the FSM SHALL enter IDLE.
REQ-021 Latency SHALL be as follows: request sampled in IDLE at cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> gnt in cycle WAIT_CYCLES+1 -> IDLE in cycle WAIT_CYCLES+2.
REQ-022 rom_en and rom_ce SHALL be 0 outside ACCESS, and rom_data SHALL never be sampled outside ACCESS.
REQ-023 rdata SHALL hold its value until the next capture; gnt0 and gnt1 SHALL never both be 1 in the same cycle.
REQ-024 Requests arriving during ACCESS or DONE SHALL be ignored until the next IDLE, with no loss provided the req is held.
REQ-025 If the owner's req drops during ACCESS, the access SHALL still complete and gnt SHALL still pulse.
REQ-026 A requester holding req high after its gnt SHALL be treated as a new request in the following IDLE cycle; round-robin then SHALL favour the other requester if it is active.
REQ-027 rom_addr SHALL hold its last value outside ACCESS.

Reset
REQ-028 When rst=1, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, rdata=8'h00, rom_addr=4'h0, rom_en=0, rom_ce=0, gnt0=0, gnt1=0, busy=0, pointer=1, counter=0.
REQ-029 Reset asserted mid-ACCESS or mid-DONE SHALL abort the transfer with no gnt issued. After rst deasserts, the first rising edge SHALL resume arbitration from IDLE.

Verification
REQ-030 Bench SHALL connect the team 16x8 ROM (contents 0:0A 1:37 2:F4 3:00 4:09 5:FF 6:11 7:01 8:10 9:15 A:1D B:25 C:60 D:90 E:70 F:91) and cover the directed scenarios below.
REQ-031 Scenario, WAIT_CYCLES=1: req0 with addr0=2 -> rom_en=rom_ce=1 in cycle 1 only; gnt0=1 with rdata=8'hF4 in cycle 2; busy=0 in cycle 3.
REQ-032 Scenario: req0 (addr 5) and req1 (addr 15) both raised in the same cycle after reset -> gnt0 first with rdata=8'hFF, then gnt1 with rdata=8'h91; no overlap of gnt0 and gnt1.
REQ-033 Scenario: req0 (addr 0) and req1 (addr 1) both held high continuously -> grants alternate gnt0/gnt1/gnt0 with rdata 0A/37/0A, one grant every 3 cycles.
REQ-034 Scenario, WAIT_CYCLES=3: req1 with addr1=12 -> rom_en high for exactly 3 cycles; gnt1 with rdata=8'h60 in cycle 4.
REQ-035 Scenario: rst asserted in the middle of ACCESS -> outputs reach reset values with no clock edge; no gnt is issued; after release, a held req0 (addr 13) is served with rdata=8'h90.
